// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions used by the control decoder and the
// instruction-memory program loader: opcode/funct constants, field widths
// and the symbolic op_sel enumeration.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;
  localparam int unsigned OP_SEL_W = 4;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  // Symbolic operation select; codes 10..15 are illegal
  typedef enum logic [OP_SEL_W-1:0] {
    OPS_ADD  = 4'd0,
    OPS_SUB  = 4'd1,
    OPS_AND  = 4'd2,
    OPS_OR   = 4'd3,
    OPS_SLT  = 4'd4,
    OPS_LW   = 4'd5,
    OPS_SW   = 4'd6,
    OPS_BEQ  = 4'd7,
    OPS_ADDI = 4'd8,
    OPS_J    = 4'd9
  } op_sel_e;

  // Assemble an R-type word; shamt is always zero for the supported ops
  function automatic logic [INSTR_W-1:0] rtype_word(
    input logic [REG_W-1:0]   rs,
    input logic [REG_W-1:0]   rt,
    input logic [REG_W-1:0]   rd,
    input logic [FUNCT_W-1:0] funct
  );
    return {OP_RTYPE, rs, rt, rd, {SHAMT_W{1'b0}}, funct};
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: symbolic op_sel plus register/immediate/target
// fields -> 32-bit MIPS instruction word. Fields not used by an op are
// forced to zero. Illegal op_sel codes raise illegal_c and give word_c = 0.
// Ports:
//   op_sel    in  4   operation select
//   rs/rt/rd  in  5   register fields
//   imm       in  16  immediate / offset
//   target    in  26  jump target
//   word_c    out 32  encoded instruction
//   illegal_c out 1   op_sel is not a supported operation
module instr_encoder
  import mips_pkg::*;
(
  input  logic [OP_SEL_W-1:0] op_sel,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TARGET_W-1:0] target,
  output logic [INSTR_W-1:0]  word_c,
  output logic                illegal_c
);

  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    case (op_sel)
      OPS_ADD:  word_c = rtype_word(rs, rt, rd, FUNCT_ADD);
      OPS_SUB:  word_c = rtype_word(rs, rt, rd, FUNCT_SUB);
      OPS_AND:  word_c = rtype_word(rs, rt, rd, FUNCT_AND);
      OPS_OR:   word_c = rtype_word(rs, rt, rd, FUNCT_OR);
      OPS_SLT:  word_c = rtype_word(rs, rt, rd, FUNCT_SLT);
      OPS_LW:   word_c = {OP_LW,   rs, rt, imm};
      OPS_SW:   word_c = {OP_SW,   rs, rt, imm};
      OPS_BEQ:  word_c = {OP_BEQ,  rs, rt, imm};
      OPS_ADDI: word_c = {OP_ADDI, rs, rt, imm};
      OPS_J:    word_c = {OP_J,    target};
      default:  illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader. Accepts symbolic instructions over a
// valid/ready stream, encodes them and writes them to consecutive word
// addresses starting at 0. One word per two cycles (ACCEPT, WRITE).
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a running XOR checksum
// of all words written in the current load.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 begin a load (honoured in IDLE, DONE, ERROR)
//   in_valid / in_ready   instruction stream handshake
//   op_sel, rs, rt, rd,
//   imm, target, last     instruction fields, last marks final word
//   imem_we/addr/wdata    instruction-memory write port
//   busy, done, err       status levels
//   word_count            words written in the current load
//   checksum              XOR of words written (macro only)
module imem_program_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_SEL_W-1:0] op_sel,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TARGET_W-1:0] target,
  input  logic                last,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [INSTR_W-1:0]  checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e                state;
  logic [ADDR_W-1:0]     addr_cnt;
  logic                  last_q;
  logic [INSTR_W-1:0]    enc_word_c;
  logic                  enc_illegal_c;

  // Encoder sees the live fields; they are only captured on the handshake
  instr_encoder u_encoder (
    .op_sel    (op_sel),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .imm       (imm),
    .target    (target),
    .word_c    (enc_word_c),
    .illegal_c (enc_illegal_c)
  );

  // Loader FSM with registered outputs; imem_wdata doubles as the word register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_ACCEPT;
            addr_cnt   <= '0;
            word_count <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
          end
        end

        S_ACCEPT: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (enc_illegal_c) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state      <= S_WRITE;
              last_q     <= last;
              imem_we    <= 1'b1;
              imem_addr  <= addr_cnt;
              imem_wdata <= enc_word_c;
            end
          end
        end

        S_WRITE: begin
          imem_we    <= 1'b0;
          addr_cnt   <= addr_cnt + ADDR_W'(1);
          word_count <= word_count + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum   <= checksum ^ imem_wdata;
`endif
          if (last_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (addr_cnt == ADDR_W'(DEPTH - 1)) begin
            // Memory full without a last marker: the word still lands
            state <= S_ERROR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            state    <= S_ACCEPT;
            in_ready <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader (DEPTH=4 so overflow is short).
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_sel = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        last = 1'b0;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [6:0]  word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int tests = 0;
  int fails = 0;
  int unsigned wr_cnt = 0;

  imem_program_loader #(.ADDR_W(6), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .target     (target),
    .last       (last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we === 1'b1) wr_cnt++;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for in_ready, present one instruction, return at the
  // negedge following the handshake edge.
  task automatic send(input logic [3:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                      input logic [4:0] f_rd, input logic [15:0] f_imm,
                      input logic [25:0] f_tgt, input logic f_last);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles", in_ready, n);
    end
    op_sel = op; rs = f_rs; rt = f_rt; rd = f_rd; imm = f_imm; target = f_tgt;
    last = f_last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_sel = 4'd15; rs = '1; rt = '1; rd = '1; imm = '1; target = '1; last = 1'b0;
  endtask

  vec_t vecs[11];
  int unsigned wr0;

  initial begin
    vecs[0]  = '{4'd0, 5'd8,  5'd9,  5'd10, 16'h0000, 26'h0,       32'h01095020};
    vecs[1]  = '{4'd0, 5'd8,  5'd9,  5'd10, 16'hFFFF, 26'h3FFFFFF, 32'h01095020};
    vecs[2]  = '{4'd1, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221822};
    vecs[3]  = '{4'd2, 5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       32'h00853024};
    vecs[4]  = '{4'd3, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FFF825};
    vecs[5]  = '{4'd4, 5'd2,  5'd3,  5'd4,  16'h0000, 26'h0,       32'h0043202A};
    vecs[6]  = '{4'd5, 5'd0,  5'd11, 5'd31, 16'h0004, 26'h0,       32'h8C0B0004};
    vecs[7]  = '{4'd6, 5'd29, 5'd31, 5'd0,  16'hFFFC, 26'h0,       32'hAFBFFFFC};
    vecs[8]  = '{4'd7, 5'd1,  5'd2,  5'd0,  16'h8000, 26'h0,       32'h10228000};
    vecs[9]  = '{4'd8, 5'd0,  5'd8,  5'd0,  16'h0005, 26'h0,       32'h20080005};
    vecs[10] = '{4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF};

    // Reset state
    #12;
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wc", {25'd0, word_count}, 32'd0);
    chk("rst_addr", {26'd0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single-word programs, one per encoding vector
    for (int i = 0; i < 11; i++) begin
      start_load();
      chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("v%0d_done_clr", i), {31'd0, done}, 32'd0);
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt, 1'b1);
      chk($sformatf("v%0d_we", i), {31'd0, imem_we}, 32'd1);
      chk($sformatf("v%0d_addr", i), {26'd0, imem_addr}, 32'd0);
      chk($sformatf("v%0d_data", i), imem_wdata, vecs[i].exp);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_we_drop", i), {31'd0, imem_we}, 32'd0);
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_wc", i), {25'd0, word_count}, 32'd1);
      chk($sformatf("v%0d_data_hold", i), imem_wdata, vecs[i].exp);
    end

    // Start while DONE with no stream: stays ACCEPT, ignores a repeat start
    start_load();
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    chk("idle_accept_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_accept_busy", {31'd0, busy}, 32'd1);

    // Three-word stream
    wr0 = wr_cnt;
    send(4'd0, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0, 1'b0);
    chk("s3_w0_we", {31'd0, imem_we}, 32'd1);
    chk("s3_w0_ready_low", {31'd0, in_ready}, 32'd0);
    chk("s3_w0_addr", {26'd0, imem_addr}, 32'd0);
    chk("s3_w0_data", imem_wdata, 32'h01095020);
    send(4'd5, 5'd0, 5'd11, 5'd0, 16'h0004, 26'h0, 1'b0);
    chk("s3_w1_addr", {26'd0, imem_addr}, 32'd1);
    chk("s3_w1_data", imem_wdata, 32'h8C0B0004);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    chk("s3_w2_addr", {26'd0, imem_addr}, 32'd2);
    chk("s3_w2_data", imem_wdata, 32'h08000000);
    @(negedge clk);
    chk("s3_done", {31'd0, done}, 32'd1);
    chk("s3_wc", {25'd0, word_count}, 32'd3);
    chk("s3_busy", {31'd0, busy}, 32'd0);
    chk("s3_writes", 32'(wr_cnt - wr0), 32'd3);

    // Illegal op_sel
    start_load();
    wr0 = wr_cnt;
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b1);
    chk("ill_we", {31'd0, imem_we}, 32'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_ready", {31'd0, in_ready}, 32'd0);
    chk("ill_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ill_writes", 32'(wr_cnt - wr0), 32'd0);
    start_load();
    chk("ill_clr_err", {31'd0, err}, 32'd0);
    chk("ill_clr_ready", {31'd0, in_ready}, 32'd1);

    // Overflow at DEPTH=4, continuing in the ACCEPT just entered
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      send(4'd8, 5'd0, 5'(i), 5'd0, 16'(i), 26'h0, 1'b0);
      chk($sformatf("ovf_addr%0d", i), {26'd0, imem_addr}, 32'(i));
      chk($sformatf("ovf_data%0d", i), imem_wdata, 32'h20000000 | (32'(i) << 16) | 32'(i));
    end
    @(negedge clk);
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_wc", {25'd0, word_count}, 32'd4);
    chk("ovf_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; op_sel = 4'd8;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("ovf_writes", 32'(wr_cnt - wr0), 32'd4);
    chk("ovf_wc_hold", {25'd0, word_count}, 32'd4);

    // Async reset during WRITE
    start_load();
    send(4'd8, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 1'b1);
    chk("rw_we_pre", {31'd0, imem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_we", {31'd0, imem_we}, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_done", {31'd0, done}, 32'd0);
    chk("rw_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start_load();
    send(4'd5, 5'd0, 5'd11, 5'd0, 16'h0004, 26'h0, 1'b1);
    chk("rw_addr", {26'd0, imem_addr}, 32'd0);
    chk("rw_data", imem_wdata, 32'h8C0B0004);
    @(negedge clk);
    chk("rw_done2", {31'd0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start_load();
    chk("cs_clr", checksum, 32'd0);
    send(4'd8, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 1'b0);
    send(4'd5, 5'd0, 5'd11, 5'd0, 16'h0004, 26'h0, 1'b1);
    @(negedge clk);
    chk("cs_done", {31'd0, done}, 32'd1);
    chk("cs_value", checksum, 32'hAC030001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side counterpart to the main control decoder.
- Accepts symbolic instructions (operation select plus register/immediate fields) over a valid/ready stream.
- Encodes each one into a 32-bit MIPS word using the opcode/funct values the control path decodes.
- Writes the words sequentially into instruction memory; used at boot or by the test harness to load programs before the core runs.

Parameters:
- ADDR_W, 6, instruction-memory word-address width.
- DEPTH, 64, number of writable words; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a load at word address 0; honoured only in IDLE, DONE or ERROR
- in_valid  in  1  instruction fields valid
- in_ready  out  1  loader can accept fields
- op_sel  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10–15 illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate/offset for LW, SW, BEQ, ADDI
- target  in  26  jump target for J
- last  in  1  marks the final instruction of the program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address being written
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in ACCEPT and WRITE
- done  out  1  program loaded; level signal
- err  out  1  illegal op or overflow; level signal
- word_count  out  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0.
- States:
  - IDLE: start → ACCEPT; clear the address counter and word_count.
  - ACCEPT: in_ready=1. On in_valid&&in_ready, register the encoded word plus last.
    - Legal op_sel → WRITE.
    - Illegal op_sel → ERROR; nothing is written.
  - WRITE: imem_we=1 for exactly one cycle with imem_addr=counter and imem_wdata=registered word. Then counter++ and word_count++.
    - If last → DONE.
    - Else if counter was DEPTH-1 → ERROR (overflow; the word is still written).
    - Else → ACCEPT.
  - DONE: done=1. start → ACCEPT with counters cleared and done cleared.
  - ERROR: err=1; word_count holds. start → ACCEPT with everything cleared.
- Latency and throughput:
  - Handshake in cycle N gives imem_we in cycle N+1.
  - Throughput is one word per 2 cycles; in_ready is low during WRITE.
  - Fields are sampled only on the handshake cycle.
- Encoding (don't-care fields are driven as 0):
  - R-type: {000000, rs, rt, rd, 00000, funct}. funct is ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - ADDI: {001000, rs, rt, imm}.
  - J: {000010, target}.
- Start outside IDLE/DONE/ERROR is ignored.
- Async reset mid-load returns to IDLE immediately; imem_we drops the same instant.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0], the XOR of all words written in the current load.
  - Cleared on start and on reset; updated in WRITE.
  - Valid when done=1.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - the op_sel enum type.
- The main control decoder uses the same package.
- One natural combinational sub-module, instr_encoder: op_sel plus fields → 32-bit word and illegal flag.
- The FSM, counters and handshake stay in the top module.

Test Plan:
- start, then ADDI rs=0 rt=8 imm=0x0005 with last=1 → one imem_we at addr 0, data 0x20080005; done=1; word_count=1.
- 3-word stream: ADD rs=8 rt=9 rd=10; LW rs=0 rt=11 imm=4; J target=0 with last → data 0x01095020, 0x8C0B0004, 0x08000000 at addrs 0,1,2; handshake-to-strobe latency 1 cycle.
- op_sel=12 → no imem_we; err=1; in_ready=0; a later start clears err and returns to ACCEPT.
- DEPTH=4, five words without last → 4 writes at addr 0–3, then err=1; word_count=4.
- Assert reset while in WRITE → imem_we, busy, done and err are all 0 immediately; a new start loads from addr 0.
- With IMEM_LOADER_CHECKSUM_EN defined, load 0x20080005 and 0x8C0B0004 → checksum = 0xAC030001 when done.
